// File: rtl/cpu_pkg.sv
// Shared CPU definitions: loader commands, loader FSM states and
// the opcode constants used by the CPU and its benches.
package cpu_pkg;

   localparam logic [3:0] LDR_CMD_IM = 4'hA;
   localparam logic [3:0] LDR_CMD_DM = 4'hB;
   localparam logic [3:0] LDR_CMD_GO = 4'hF;

   localparam logic [2:0] ST_HDR  = 3'd0;
   localparam logic [2:0] ST_LEN  = 3'd1;
   localparam logic [2:0] ST_DATA = 3'd2;
   localparam logic [2:0] ST_CSUM = 3'd3;
   localparam logic [2:0] ST_RUN  = 3'd4;
   localparam logic [2:0] ST_ERR  = 3'd5;

   localparam logic [3:0] ADD   = 4'd0;
   localparam logic [3:0] SUB   = 4'd1;
   localparam logic [3:0] LOAD  = 4'd2;
   localparam logic [3:0] STORE = 4'd3;
   localparam logic [3:0] JUMP  = 4'd4;

endpackage

// File: rtl/prog_loader.sv
// Boot loader: framed host words into IM/DM write ports, then
// releases the CPU from reset on GO.
module prog_loader
   import cpu_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_data,
   output logic              im_we,
   output logic [ADDR_W-1:0] im_addr,
   output logic [DATA_W-1:0] im_wdata,
   output logic              dm_we,
   output logic [ADDR_W-1:0] dm_addr,
   output logic [DATA_W-1:0] dm_wdata,
   output logic              cpu_reset,
   output logic              err
);

   localparam logic [DATA_W:0] MAXN    = (DATA_W+1)'(1) << ADDR_W;
   localparam logic [ADDR_W:0] REM_ONE = (ADDR_W+1)'(1);

   logic [2:0]        state_q, state_d;
   logic              tgt_q, tgt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W:0]   rem_q, rem_d;
   logic [DATA_W-1:0] sum_q, sum_d;
   logic              imwe_q, imwe_d;
   logic              dmwe_q, dmwe_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              cpur_q, cpur_d;
   logic              err_q, err_d;
   logic              hs;
   logic [3:0]        cmd;

   assign s_ready = (state_q != ST_RUN);
   assign hs      = s_valid && s_ready;
   assign cmd     = s_data[15:12];

   always_comb begin
      state_d = state_q;
      tgt_d   = tgt_q;
      addr_d  = addr_q;
      rem_d   = rem_q;
      sum_d   = sum_q;
      imwe_d  = 1'b0;
      dmwe_d  = 1'b0;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      cpur_d  = cpur_q;
      err_d   = err_q;
      if (hs) begin
         case (state_q)
            ST_HDR: begin
               if (cmd == LDR_CMD_IM || cmd == LDR_CMD_DM) begin
                  tgt_d   = (cmd == LDR_CMD_DM);
                  addr_d  = s_data[ADDR_W-1:0];
                  sum_d   = '0;
                  state_d = ST_LEN;
               end else if (cmd == LDR_CMD_GO) begin
                  cpur_d  = 1'b0;
                  state_d = ST_RUN;
               end else begin
                  err_d   = 1'b1;
                  state_d = ST_ERR;
               end
            end
            ST_LEN: begin
               if ({1'b0, s_data} > MAXN) begin
                  err_d   = 1'b1;
                  state_d = ST_ERR;
               end else if (s_data == '0) begin
                  state_d = ST_CSUM;
               end else begin
                  rem_d   = s_data[ADDR_W:0];
                  state_d = ST_DATA;
               end
            end
            ST_DATA: begin
               imwe_d  = !tgt_q;
               dmwe_d  = tgt_q;
               waddr_d = addr_q;
               wdata_d = s_data;
               addr_d  = addr_q + 1'b1;
               sum_d   = sum_q + s_data;
               rem_d   = rem_q - 1'b1;
               if (rem_q == REM_ONE) state_d = ST_CSUM;
            end
            ST_CSUM: begin
               if (s_data == sum_q) begin
                  state_d = ST_HDR;
               end else begin
                  err_d   = 1'b1;
                  state_d = ST_ERR;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_HDR;
         tgt_q   <= 1'b0;
         addr_q  <= '0;
         rem_q   <= '0;
         sum_q   <= '0;
         imwe_q  <= 1'b0;
         dmwe_q  <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
         cpur_q  <= 1'b1;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tgt_q   <= tgt_d;
         addr_q  <= addr_d;
         rem_q   <= rem_d;
         sum_q   <= sum_d;
         imwe_q  <= imwe_d;
         dmwe_q  <= dmwe_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         cpur_q  <= cpur_d;
         err_q   <= err_d;
      end
   end

   assign im_we     = imwe_q;
   assign dm_we     = dmwe_q;
   assign im_addr   = waddr_q;
   assign dm_addr   = waddr_q;
   assign im_wdata  = wdata_q;
   assign dm_wdata  = wdata_q;
   assign cpu_reset = cpur_q;
   assign err       = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: loads, checksum/count errors,
// address wrap, backpressure and mid-frame reset.
module tb_prog_loader;
   import cpu_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic [15:0] s_data = '0;
   logic        im_we, dm_we, cpu_reset, err;
   logic [7:0]  im_addr, dm_addr;
   logic [15:0] im_wdata, dm_wdata;

   int n_chk  = 0;
   int n_pass = 0;

   logic [15:0] prog [5] = '{16'h0001, 16'h1002, 16'h2004,
                             16'h3005, 16'h4000};

   always #5 clk = ~clk;

   prog_loader #(.DATA_W(16), .ADDR_W(8)) dut (
      .clk(clk), .reset(reset),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
      .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .cpu_reset(cpu_reset), .err(err)
   );

   task automatic chk(input string tag, input logic [15:0] obs,
                      input logic [15:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic send(input logic [15:0] w);
      s_valid = 1'b1;
      s_data  = w;
      @(posedge clk);
      #1;
      s_valid = 1'b0;
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset   = 1'b1;
      s_valid = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic im_frame(input logic [15:0] cs);
      send(16'hA000);
      send(16'h0005);
      for (int i = 0; i < 5; i++) begin
         send(prog[i]);
         chk("im_we", {15'd0, im_we}, 16'd1);
         chk("im_addr", {8'd0, im_addr}, 16'(i));
         chk("im_wdata", im_wdata, prog[i]);
         chk("dm_we_quiet", {15'd0, dm_we}, 16'd0);
      end
      send(cs);
      chk("csum_no_we", {15'd0, im_we}, 16'd0);
   endtask

   initial begin
      int good;
      logic [15:0] w;

      idle();
      idle();
      chk("rst_cpu_reset", {15'd0, cpu_reset}, 16'd1);
      chk("rst_err", {15'd0, err}, 16'd0);
      chk("rst_im_we", {15'd0, im_we}, 16'd0);
      chk("rst_dm_we", {15'd0, dm_we}, 16'd0);
      chk("rst_addr", {im_addr, dm_addr}, 16'h0000);
      chk("rst_wdata", im_wdata | dm_wdata, 16'h0000);
      chk("rst_s_ready", {15'd0, s_ready}, 16'd1);
      reset = 1'b0;

      im_frame(16'hA00C);
      chk("im_err", {15'd0, err}, 16'd0);
      chk("pre_go_cpu_reset", {15'd0, cpu_reset}, 16'd1);
      send(16'hF000);
      chk("go_cpu_reset", {15'd0, cpu_reset}, 16'd0);
      chk("go_s_ready", {15'd0, s_ready}, 16'd0);

      do_reset();
      chk("rerst_cpu_reset", {15'd0, cpu_reset}, 16'd1);
      send(16'hB001);
      send(16'h0001);
      send(16'h0064);
      chk("dm_we", {15'd0, dm_we}, 16'd1);
      chk("dm_addr", {8'd0, dm_addr}, 16'h0001);
      chk("dm_wdata", dm_wdata, 16'd100);
      chk("dm_no_im_we", {15'd0, im_we}, 16'd0);
      send(16'h0064);
      chk("dm_we_1cyc", {15'd0, dm_we}, 16'd0);
      chk("dm_err", {15'd0, err}, 16'd0);
      send(16'hA010);
      send(16'h0000);
      send(16'h0000);
      chk("n0_err", {15'd0, err}, 16'd0);
      chk("n0_no_we", {14'd0, im_we, dm_we}, 16'd0);

      do_reset();
      im_frame(16'hA00D);
      chk("cs_err", {15'd0, err}, 16'd1);
      send(16'hF000);
      chk("cs_cpu_reset", {15'd0, cpu_reset}, 16'd1);
      chk("cs_s_ready", {15'd0, s_ready}, 16'd1);
      send(16'h0001);
      chk("err_discard", {14'd0, im_we, dm_we}, 16'd0);
      chk("err_sticky", {15'd0, err}, 16'd1);

      do_reset();
      chk("rst_clears_err", {15'd0, err}, 16'd0);
      send(16'hA0FF);
      send(16'h0002);
      send(16'h1111);
      chk("wrap_addr0", {7'd0, im_we, im_addr}, 16'h01FF);
      send(16'h2222);
      chk("wrap_addr1", {7'd0, im_we, im_addr}, 16'h0100);
      chk("wrap_data1", im_wdata, 16'h2222);
      send(16'h3333);
      chk("wrap_err", {15'd0, err}, 16'd0);

      do_reset();
      send(16'hA000);
      send(16'h0101);
      chk("badn_err", {15'd0, err}, 16'd1);
      chk("badn_no_we", {14'd0, im_we, dm_we}, 16'd0);
      send(16'h5555);
      chk("badn_discard", {14'd0, im_we, dm_we}, 16'd0);

      do_reset();
      send(16'hA000);
      send(16'h0100);
      good = 0;
      for (int i = 0; i < 256; i++) begin
         w = 16'(i);
         send(w);
         if (im_we && im_addr == w[7:0] && im_wdata == w) good++;
      end
      chk("n256_writes", 16'(good), 16'd256);
      send(16'h7F80);
      chk("n256_err", {15'd0, err}, 16'd0);

      do_reset();
      send(16'hA000);
      send(16'h0003);
      good = 0;
      for (int i = 1; i <= 3; i++) begin
         idle();
         if (im_we || dm_we) good = good + 100;
         w = 16'(i * 16'h0011);
         send(w);
         if (im_we && im_wdata == w && im_addr == 8'(i - 1)) good++;
      end
      chk("bp_strobes", 16'(good), 16'd3);
      idle();
      chk("bp_gap_quiet", {15'd0, im_we}, 16'd0);
      send(16'h0066);
      chk("bp_err", {15'd0, err}, 16'd0);

      do_reset();
      send(16'hA000);
      send(16'h0005);
      send(prog[0]);
      send(prog[1]);
      chk("mid_we_before", {15'd0, im_we}, 16'd1);
      do_reset();
      chk("mid_we_dropped", {15'd0, im_we}, 16'd0);
      chk("mid_cpu_reset", {15'd0, cpu_reset}, 16'd1);
      im_frame(16'hA00C);
      chk("mid_reload_err", {15'd0, err}, 16'd0);
      send(16'hF000);
      chk("mid_go", {15'd0, cpu_reset}, 16'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
